// File: rtl/muldiv_seq_pkg.sv
// Shared constants for the RV32M multiply/divide sequencer.
// - MFun7: funct7 value that marks an M-extension R-type instruction.
// - Fun*: the eight funct3 operation codes.
// - Md*: 2-bit FSM state encodings.
// - Helpers that tell whether each operand is treated as signed for a given funct3.
package muldiv_seq_pkg;

    localparam logic [6:0] MFun7 = 7'h01;

    localparam logic [2:0] FunMul    = 3'd0;
    localparam logic [2:0] FunMulh   = 3'd1;
    localparam logic [2:0] FunMulhsu = 3'd2;
    localparam logic [2:0] FunMulhu  = 3'd3;
    localparam logic [2:0] FunDiv    = 3'd4;
    localparam logic [2:0] FunDivu   = 3'd5;
    localparam logic [2:0] FunRem    = 3'd6;
    localparam logic [2:0] FunRemu   = 3'd7;

    localparam logic [1:0] MdIdle = 2'd0;
    localparam logic [1:0] MdCalc = 2'd1;
    localparam logic [1:0] MdFix  = 2'd2;
    localparam logic [1:0] MdDone = 2'd3;

    function automatic logic is_m_fun7(logic [6:0] fun7);
        return fun7 == MFun7;
    endfunction

    // rs1 is signed for every op except MULHU, DIVU and REMU.
    function automatic logic fun3_signed_a(logic [2:0] fun3);
        return (fun3 == FunMul) || (fun3 == FunMulh) || (fun3 == FunMulhsu) ||
               (fun3 == FunDiv) || (fun3 == FunRem);
    endfunction

    // rs2 is additionally unsigned for MULHSU.
    function automatic logic fun3_signed_b(logic [2:0] fun3);
        return (fun3 == FunMul) || (fun3 == FunMulh) || (fun3 == FunDiv) || (fun3 == FunRem);
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the EX stage and the multiply/divide sequencer.
// - i_valid/i_fun3/i_A/i_B/i_rd/i_flush: request from EX (driven by master).
// - o_stall/o_busy/o_done/o_result/o_rd: status and result (driven by slave).
interface muldiv_seq_if;

    logic        i_valid;
    logic [2:0]  i_fun3;
    logic [31:0] i_A;
    logic [31:0] i_B;
    logic [4:0]  i_rd;
    logic        i_flush;
    logic        o_stall;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_result;
    logic [4:0]  o_rd;

    modport master (
        output i_valid, i_fun3, i_A, i_B, i_rd, i_flush,
        input  o_stall, o_busy, o_done, o_result, o_rd
    );

    modport slave (
        input  i_valid, i_fun3, i_A, i_B, i_rd, i_flush,
        output o_stall, o_busy, o_done, o_result, o_rd
    );

endinterface

// File: rtl/muldiv_dp.sv
// Datapath for the multiply/divide sequencer.
// - i_load: capture operand magnitudes and result sign using i_load_fun3.
// - i_step: one shift-add (multiply) or shift-subtract-restore (divide) iteration.
// - i_fun3: latched operation, selects iteration kind and sign fix-up.
// - o_result: sign-corrected result, valid after the 32nd step.
// prod_q is shared: multiply keeps {high, low} of the product; divide keeps
// {partial remainder, dividend shifting out / quotient shifting in}.
module muldiv_dp
    import muldiv_seq_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [2:0]  i_load_fun3,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [2:0]  i_fun3,
    output logic [31:0] o_result
);

    logic [63:0] prod_q, prod_d;
    logic [31:0] bmag_q, bmag_d;
    logic        res_neg_q, res_neg_d;

    logic        neg_a, neg_b, is_mul;
    logic [31:0] a_mag, b_mag;
    logic [32:0] add_a, add_b, sum;
    logic [63:0] prod_neg;

    always_comb begin
        neg_a = fun3_signed_a(i_load_fun3) && i_a[31];
        neg_b = fun3_signed_b(i_load_fun3) && i_b[31];
        a_mag = neg_a ? -i_a : i_a;
        b_mag = neg_b ? -i_b : i_b;

        is_mul = !i_fun3[2];
        add_a  = is_mul ? {1'b0, prod_q[63:32]} : {prod_q[63:32], prod_q[31]};
        add_b  = {1'b0, bmag_q};
        sum    = is_mul ? (add_a + add_b) : (add_a - add_b);

        prod_d    = prod_q;
        bmag_d    = bmag_q;
        res_neg_d = res_neg_q;

        if (i_load) begin
            prod_d    = {32'd0, a_mag};
            bmag_d    = b_mag;
            // Remainder follows the dividend; everything else follows the product/quotient.
            res_neg_d = (i_load_fun3 == FunRem) ? neg_a : (neg_a ^ neg_b);
        end else if (i_step) begin
            if (is_mul) begin
                prod_d = prod_q[0] ? {sum, prod_q[31:1]} : {1'b0, prod_q[63:32], prod_q[31:1]};
            end else begin
                // No borrow means the divisor fits: keep the difference, shift in a 1.
                prod_d = !sum[32] ? {sum[31:0], prod_q[30:0], 1'b1}
                                  : {add_a[31:0], prod_q[30:0], 1'b0};
            end
        end
    end

    always_comb begin
        prod_neg = -prod_q;
        o_result = prod_q[31:0];
        unique case (i_fun3)
            FunMul:                       o_result = res_neg_q ? prod_neg[31:0] : prod_q[31:0];
            FunMulh, FunMulhsu, FunMulhu: o_result = res_neg_q ? prod_neg[63:32] : prod_q[63:32];
            FunDiv:                       o_result = res_neg_q ? -prod_q[31:0] : prod_q[31:0];
            FunDivu:                      o_result = prod_q[31:0];
            FunRem:                       o_result = res_neg_q ? -prod_q[63:32] : prod_q[63:32];
            FunRemu:                      o_result = prod_q[63:32];
            default:                      o_result = prod_q[31:0];
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prod_q    <= 64'd0;
            bmag_q    <= 32'd0;
            res_neg_q <= 1'b0;
        end else begin
            prod_q    <= prod_d;
            bmag_q    <= bmag_d;
            res_neg_q <= res_neg_d;
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer beside the EX-stage ALU.
// - i_clk, i_rst_n: clock and asynchronous active-low reset.
// - bus (slave): request (valid, fun3, A, B, rd, flush) and response
//   (stall, busy, done, result, rd).
// Owns the FSM, iteration counter, divide-by-zero/overflow shortcuts,
// stall/done generation and the result/rd output registers.
module muldiv_seq
    import muldiv_seq_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    muldiv_seq_if.slave  bus
);

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  fun3_q, fun3_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  rd_out_q, rd_out_d;

    logic        div_zero, div_ovf;
    logic [31:0] special_res;
    logic        dp_load, dp_step;
    logic [31:0] dp_result;

    always_comb begin
        div_zero = bus.i_fun3[2] && (bus.i_B == 32'd0);
        div_ovf  = bus.i_fun3[2] && !bus.i_fun3[0] &&
                   (bus.i_A == 32'h8000_0000) && (bus.i_B == 32'hFFFF_FFFF);
        // fun3[1] separates REM/REMU from DIV/DIVU.
        if (div_zero) begin
            special_res = bus.i_fun3[1] ? bus.i_A : 32'hFFFF_FFFF;
        end else begin
            special_res = bus.i_fun3[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fun3_d   = fun3_q;
        rd_d     = rd_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        dp_load  = 1'b0;
        dp_step  = 1'b0;

        if (bus.i_flush) begin
            state_d = MdIdle;
        end else begin
            case (state_q)
                MdIdle: begin
                    if (bus.i_valid) begin
                        fun3_d = bus.i_fun3;
                        rd_d   = bus.i_rd;
                        if (div_zero || div_ovf) begin
                            result_d = special_res;
                            rd_out_d = bus.i_rd;
                            state_d  = MdDone;
                        end else begin
                            dp_load = 1'b1;
                            cnt_d   = 5'd0;
                            state_d = MdCalc;
                        end
                    end
                end
                MdCalc: begin
                    dp_step = 1'b1;
                    cnt_d   = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = MdFix;
                    end
                end
                MdFix: begin
                    result_d = dp_result;
                    rd_out_d = rd_q;
                    state_d  = MdDone;
                end
                MdDone: begin
                    state_d = MdIdle;
                end
                default: begin
                    state_d = MdIdle;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= MdIdle;
            cnt_q    <= 5'd0;
            fun3_q   <= 3'd0;
            rd_q     <= 5'd0;
            result_q <= 32'd0;
            rd_out_q <= 5'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fun3_q   <= fun3_d;
            rd_q     <= rd_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    muldiv_dp u_dp (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (dp_load),
        .i_step      (dp_step),
        .i_load_fun3 (bus.i_fun3),
        .i_a         (bus.i_A),
        .i_b         (bus.i_B),
        .i_fun3      (fun3_q),
        .o_result    (dp_result)
    );

    // Stall drops in DONE so EX advances together with the result.
    assign bus.o_stall  = bus.i_valid && (state_q != MdDone);
    assign bus.o_busy   = (state_q != MdIdle);
    assign bus.o_done   = (state_q == MdDone);
    assign bus.o_result = result_q;
    assign bus.o_rd     = rd_out_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table plus flush,
// reset and back-to-back sequences.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    typedef struct {
        string       name;
        logic [2:0]  fun3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vecs[$];

    muldiv_seq_if bus ();

    muldiv_seq dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [2:0] fun3, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] rd,
                                input logic [31:0] exp, input int lat);
        vec_t v;
        v.name = name; v.fun3 = fun3; v.a = a; v.b = b; v.rd = rd; v.exp = exp; v.lat = lat;
        return v;
    endfunction

    // Called just after an edge with the DUT idle; the next edge is the accept edge.
    task automatic run_op(input vec_t v);
        int   lat;
        logic seen;
        logic stall_ok;
        bus.i_valid = 1'b1;
        bus.i_fun3  = v.fun3;
        bus.i_A     = v.a;
        bus.i_B     = v.b;
        bus.i_rd    = v.rd;
        lat = 0; seen = 1'b0; stall_ok = 1'b1;
        #1;
        if (bus.o_stall !== 1'b1) stall_ok = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (bus.o_done === 1'b1) seen = 1'b1;
            else if (bus.o_stall !== 1'b1) stall_ok = 1'b0;
        end
        check({v.name, "/done_seen"}, {31'd0, seen}, 32'd1);
        check({v.name, "/latency"}, lat, v.lat);
        check({v.name, "/result"}, bus.o_result, v.exp);
        check({v.name, "/rd"}, {27'd0, bus.o_rd}, {27'd0, v.rd});
        check({v.name, "/stall_in_done"}, {31'd0, bus.o_stall}, 32'd0);
        check({v.name, "/stall_while_wait"}, {31'd0, stall_ok}, 32'd1);
        bus.i_valid = 1'b0;
        @(posedge clk); #1;
        check({v.name, "/idle_after"}, {30'd0, bus.o_busy, bus.o_done}, 32'd0);
    endtask

    initial begin
        int   dones;
        int   lat;
        logic seen;
        checks = 0;
        errors = 0;

        vecs.push_back(mk("mul_7_m3",      FunMul,    32'd7,         32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34));
        vecs.push_back(mk("mulh_min_sq",   FunMulh,   32'h80000000,  32'h80000000, 5'd6,  32'h40000000, 34));
        vecs.push_back(mk("mulhu_max_sq",  FunMulhu,  32'hFFFFFFFF,  32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 34));
        vecs.push_back(mk("mulhsu_m1",     FunMulhsu, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 34));
        vecs.push_back(mk("mulh_m1_m1",    FunMulh,   32'hFFFFFFFF,  32'hFFFFFFFF, 5'd9,  32'h00000000, 34));
        vecs.push_back(mk("mulh_m1_2",     FunMulh,   32'hFFFFFFFF,  32'd2,        5'd10, 32'hFFFFFFFF, 34));
        vecs.push_back(mk("div_m7_2",      FunDiv,    32'hFFFFFFF9,  32'd2,        5'd11, 32'hFFFFFFFD, 34));
        vecs.push_back(mk("rem_m7_2",      FunRem,    32'hFFFFFFF9,  32'd2,        5'd12, 32'hFFFFFFFF, 34));
        vecs.push_back(mk("divu_max_16",   FunDivu,   32'hFFFFFFFF,  32'd16,       5'd13, 32'h0FFFFFFF, 34));
        vecs.push_back(mk("remu_100_7",    FunRemu,   32'd100,       32'd7,        5'd14, 32'd2,        34));
        vecs.push_back(mk("div_20_m3",     FunDiv,    32'd20,        32'hFFFFFFFD, 5'd15, 32'hFFFFFFFA, 34));
        vecs.push_back(mk("rem_20_m3",     FunRem,    32'd20,        32'hFFFFFFFD, 5'd16, 32'd2,        34));
        vecs.push_back(mk("rem_m20_3",     FunRem,    32'hFFFFFFEC,  32'd3,        5'd17, 32'hFFFFFFFE, 34));
        vecs.push_back(mk("divu_min_max",  FunDivu,   32'h80000000,  32'hFFFFFFFF, 5'd18, 32'd0,        34));
        vecs.push_back(mk("remu_min_max",  FunRemu,   32'h80000000,  32'hFFFFFFFF, 5'd19, 32'h80000000, 34));
        vecs.push_back(mk("divu_5_0",      FunDivu,   32'd5,         32'd0,        5'd20, 32'hFFFFFFFF, 1));
        vecs.push_back(mk("rem_5_0",       FunRem,    32'd5,         32'd0,        5'd21, 32'd5,        1));
        vecs.push_back(mk("div_ovf",       FunDiv,    32'h80000000,  32'hFFFFFFFF, 5'd22, 32'h80000000, 1));
        vecs.push_back(mk("rem_ovf",       FunRem,    32'h80000000,  32'hFFFFFFFF, 5'd23, 32'd0,        1));

        // Reset state, including stall following i_valid during reset.
        rst_n = 1'b0;
        bus.i_valid = 1'b1; bus.i_flush = 1'b0; bus.i_fun3 = 3'd0;
        bus.i_A = 32'd0; bus.i_B = 32'd0; bus.i_rd = 5'd0;
        #2;
        check("reset/stall_valid_hi", {31'd0, bus.o_stall}, 32'd1);
        bus.i_valid = 1'b0;
        #1;
        check("reset/stall", {31'd0, bus.o_stall}, 32'd0);
        check("reset/busy_done", {30'd0, bus.o_busy, bus.o_done}, 32'd0);
        check("reset/result", bus.o_result, 32'd0);
        check("reset/rd", {27'd0, bus.o_rd}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) run_op(vecs[i]);

        // Flush in the middle of CALC.
        bus.i_valid = 1'b1; bus.i_fun3 = FunMul; bus.i_A = 32'd9; bus.i_B = 32'd9; bus.i_rd = 5'd1;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        check("flush/busy_before", {31'd0, bus.o_busy}, 32'd1);
        bus.i_flush = 1'b1;
        @(posedge clk); #1;
        check("flush/idle_next", {30'd0, bus.o_busy, bus.o_done}, 32'd0);
        bus.i_flush = 1'b0; bus.i_valid = 1'b0;
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.o_done === 1'b1) dones++;
        end
        check("flush/no_done", dones, 0);
        run_op(mk("mul_3_4", FunMul, 32'd3, 32'd4, 5'd2, 32'd12, 34));

        // Reset mid-CALC abandons the operation and clears outputs at once.
        bus.i_valid = 1'b1; bus.i_fun3 = FunDivu; bus.i_A = 32'd1000; bus.i_B = 32'd3;
        bus.i_rd = 5'd30;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid/busy_done", {30'd0, bus.o_busy, bus.o_done}, 32'd0);
        check("rst_mid/result", bus.o_result, 32'd0);
        check("rst_mid/rd", {27'd0, bus.o_rd}, 32'd0);
        check("rst_mid/stall", {31'd0, bus.o_stall}, 32'd1);
        bus.i_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back DIVs with i_valid held across the retirement.
        bus.i_valid = 1'b1; bus.i_fun3 = FunDiv; bus.i_A = 32'd100; bus.i_B = 32'd7;
        bus.i_rd = 5'd3;
        lat = 0; seen = 1'b0; dones = 0;
        while (!seen && lat < 100) begin
            @(posedge clk); #1; lat++;
            if (bus.o_done === 1'b1) seen = 1'b1;
        end
        if (seen) dones++;
        check("b2b/first_latency", lat, 34);
        check("b2b/first_result", bus.o_result, 32'd14);
        check("b2b/first_rd", {27'd0, bus.o_rd}, 32'd3);
        bus.i_A = 32'd200; bus.i_rd = 5'd4;
        @(posedge clk); #1;
        check("b2b/idle_gap", {29'd0, bus.o_busy, bus.o_done, bus.o_stall}, 32'd1);
        lat = 0; seen = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge clk); #1; lat++;
            if (bus.o_done === 1'b1) seen = 1'b1;
        end
        if (seen) dones++;
        check("b2b/second_latency", lat, 34);
        check("b2b/second_result", bus.o_result, 32'd28);
        check("b2b/second_rd", {27'd0, bus.o_rd}, 32'd4);
        bus.i_valid = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.o_done === 1'b1) dones++;
        end
        check("b2b/done_pulses", dones, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
